cc_mshr: RTL

- Parametrised miss-status holding register block for the cache controller. It replaces the single in-order miss request FIFO with NUM_ENTRIES outstanding line fills.
- Same-line misses are coalesced into one entry.
- Each entry gets its own AXI ID, so memory may return lines out of order.
- Sits between the tag comparator's miss output and the memory AR/R channels. Fill-completion events go to the fill/reorder units.

---
 rtl/cc_mshr.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cc_mshr.sv
// cc_mshr: miss-status holding registers for the cache controller.
// Tracks up to NUM_ENTRIES outstanding line fills and coalesces same-line misses.
// Each entry's index is its AXI ID, so memory may return lines in any order.
// Completed fills are reported on the fill_* outputs.
module cc_mshr #(
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_ENTRIES = 4,
    parameter int ID_WIDTH    = 4,
    parameter int LINE_BYTES  = 64,
    parameter int BEAT_BYTES  = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        miss_valid_i,
    output logic                                        miss_ready_o,
    input  logic [ADDR_WIDTH-1:0]                       miss_addr_i,
    output logic                                        miss_merged_o,
    output logic [ID_WIDTH-1:0]                         miss_id_o,
    output logic                                        mem_arvalid_o,
    input  logic                                        mem_arready_i,
    output logic [ID_WIDTH-1:0]                         mem_arid_o,
    output logic [ADDR_WIDTH-1:0]                       mem_araddr_o,
    output logic [3:0]                                  mem_arlen_o,
    output logic [2:0]                                  mem_arsize_o,
    output logic [1:0]                                  mem_arburst_o,
    input  logic                                        mem_rvalid_i,
    output logic                                        mem_rready_o,
    input  logic [ID_WIDTH-1:0]                         mem_rid_i,
    input  logic                                        mem_rlast_i,
    output logic                                        fill_done_o,
    output logic [ID_WIDTH-1:0]                         fill_id_o,
    output logic [ADDR_WIDTH-$clog2(LINE_BYTES)-1:0]    fill_line_o,
    output logic [3:0]                                  fill_merge_cnt_o,
    output logic [4:0]                                  outstanding_o,
    output logic                                        err_o
);

    localparam int LINE_OFF = $clog2(LINE_BYTES);
    localparam int BEAT_OFF = $clog2(BEAT_BYTES);
    localparam int BEATS    = LINE_BYTES / BEAT_BYTES;
    localparam int LINE_W   = ADDR_WIDTH - LINE_OFF;
    localparam int IDX_W    = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CNT_W    = $clog2(NUM_ENTRIES + 1);
    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ~ADDR_WIDTH'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {FREE, PEND, ISSUED} state_t;

    state_t            st      [NUM_ENTRIES];
    logic [LINE_W-1:0] line_q  [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0] crit_q [NUM_ENTRIES];
    logic [3:0]        beat_q  [NUM_ENTRIES];
    logic [3:0]        merge_q [NUM_ENTRIES];

    // Issue queue of entry indices, in allocation order.
    logic [IDX_W-1:0]  iq      [NUM_ENTRIES];
    logic [IDX_W-1:0]  iq_head, iq_tail;
    logic [CNT_W-1:0]  iq_cnt;

    logic              active_q;
    logic [LINE_W-1:0] miss_line;
    logic [IDX_W-1:0]  rid_idx, free_idx, match_idx, head_idx;
    logic              any_free, match_hit, accept, do_alloc;
    logic              r_hs, r_ok, r_done, ar_hs;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(NUM_ENTRIES - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    assign miss_line = miss_addr_i[ADDR_WIDTH-1:LINE_OFF];
    assign rid_idx   = mem_rid_i[IDX_W-1:0];
    assign head_idx  = iq[iq_head];

    assign r_hs   = mem_rvalid_i & mem_rready_o;
    assign r_ok   = r_hs && (int'(mem_rid_i) < NUM_ENTRIES) && (st[rid_idx] == ISSUED);
    assign r_done = r_ok & mem_rlast_i;

    // Lowest FREE entry and the busy entry (if any) holding the miss line.
    // An entry taking its last beat this cycle is leaving, so it cannot absorb a miss.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        any_free  = 1'b0;
        free_idx  = '0;
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (st[i] == FREE) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (st[i] != FREE && line_q[i] == miss_line &&
                !(r_done && rid_idx == IDX_W'(i))) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // Nothing is accepted until the block has seen a clock out of reset.
    assign miss_ready_o = any_free & active_q;
    assign mem_rready_o = active_q;
    assign accept       = miss_valid_i & miss_ready_o;
    assign do_alloc     = accept & ~match_hit;

    assign mem_arvalid_o = (iq_cnt != '0);
    assign ar_hs         = mem_arvalid_o & mem_arready_i;
    assign mem_arid_o    = mem_arvalid_o ? ID_WIDTH'(head_idx) : '0;
    assign mem_araddr_o  = mem_arvalid_o ? crit_q[head_idx] : '0;
    assign mem_arlen_o   = mem_arvalid_o ? LAST_BEAT : 4'd0;
    assign mem_arsize_o  = mem_arvalid_o ? 3'(BEAT_OFF) : 3'd0;
    assign mem_arburst_o = mem_arvalid_o ? 2'b10 : 2'b00;

    // Entry lifecycle, issue-queue pointers, fill reporting and error tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) st[i] <= FREE;
            active_q         <= 1'b0;
            iq_head          <= '0;
            iq_tail          <= '0;
            iq_cnt           <= '0;
            miss_merged_o    <= 1'b0;
            miss_id_o        <= '0;
            fill_done_o      <= 1'b0;
            fill_id_o        <= '0;
            fill_line_o      <= '0;
            fill_merge_cnt_o <= '0;
            outstanding_o    <= '0;
            err_o            <= 1'b0;
        end else begin
            active_q      <= 1'b1;
            miss_merged_o <= accept & match_hit;
            if (accept) miss_id_o <= ID_WIDTH'(match_hit ? match_idx : free_idx);

            // Allocation, AR issue and completion always touch different entries
            // (FREE, PEND and ISSUED respectively).
            if (do_alloc) begin
                st[free_idx] <= PEND;
                iq_tail      <= ptr_inc(iq_tail);
            end
            if (ar_hs) begin
                st[head_idx] <= ISSUED;
                iq_head      <= ptr_inc(iq_head);
            end
            iq_cnt <= iq_cnt + CNT_W'(do_alloc) - CNT_W'(ar_hs);

            fill_done_o <= r_done;
            if (r_done) begin
                st[rid_idx]      <= FREE;
                fill_id_o        <= mem_rid_i;
                fill_line_o      <= line_q[rid_idx];
                fill_merge_cnt_o <= merge_q[rid_idx];
            end

            if (r_hs && (!r_ok || (mem_rlast_i ? (beat_q[rid_idx] != LAST_BEAT)
                                               : (beat_q[rid_idx] == LAST_BEAT))))
                err_o <= 1'b1;

            outstanding_o <= outstanding_o + 5'(do_alloc) - 5'(r_done);
        end
    end

    // Per-entry payload and issue-queue storage; only read while the owning entry is busy.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; entry state gates every use, so reset only the state.
        if (do_alloc) begin
            line_q[free_idx]  <= miss_line;
            crit_q[free_idx]  <= miss_addr_i & BEAT_MASK;
            beat_q[free_idx]  <= 4'd0;
            merge_q[free_idx] <= 4'd1;
            iq[iq_tail]       <= free_idx;
        end
        if (accept && match_hit && merge_q[match_idx] != 4'hF)
            merge_q[match_idx] <= merge_q[match_idx] + 4'd1;
        if (r_ok && !mem_rlast_i && beat_q[rid_idx] != LAST_BEAT)
            beat_q[rid_idx] <= beat_q[rid_idx] + 4'd1;
    end

endmodule
